// File: rtl/sat_cnt_update.sv
// Consumer end of the BPU saturating-counter FIFO: pops the counter captured at
// prediction time, applies the 2-bit saturating update and writes it back to the PHT.
module sat_cnt_update #(
  parameter int         IDX_W          = 10,
  parameter int         MISS_TIMEOUT   = 4,
  parameter logic [1:0] DEF_CNT        = 2'b01,
  parameter bit         SKIP_SAT_WRITE = 1'b1,
  parameter int         STAT_W         = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_br_valid,
  input  logic              i_br_taken,
  input  logic [IDX_W-1:0]  i_br_idx,
  output logic              o_br_ready,
  input  logic [1:0]        i_fifo_rdcnt,
  input  logic              i_fifo_empty,
  output logic              o_fifo_read,
  output logic              o_pht_wr_valid,
  output logic [IDX_W-1:0]  o_pht_wr_idx,
  output logic [1:0]        o_pht_wr_cnt,
  input  logic              i_pht_wr_ready,
  output logic [STAT_W-1:0] o_upd_cnt,
  output logic [STAT_W-1:0] o_miss_cnt
);

  // The timeout counter only ever holds 0 .. MISS_TIMEOUT-1.
  localparam int TO_W = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MISS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_CNT, WRITE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx_q;
  logic                taken_q;
  logic [1:0]          cnt_q;
  logic [TO_W-1:0]     to_cnt;
  logic [STAT_W-1:0]   upd_q;
  logic [STAT_W-1:0]   miss_q;

  logic       br_hs;
  logic       pop;
  logic       timeout;
  logic       load;
  logic       taken_sel;
  logic [1:0] old_cnt;
  logic [1:0] new_cnt;
  logic       skip;

  function automatic logic [1:0] sat_update(input logic [1:0] old, input logic taken);
    if (taken) return (old == 2'b11) ? old : old + 2'b01;
    return (old == 2'b00) ? old : old - 2'b01;
  endfunction

  assign o_br_ready = (state == IDLE) & ~i_rst;

  always_comb begin
    br_hs   = i_br_valid & o_br_ready;
    pop     = 1'b0;
    timeout = 1'b0;
    if (!i_rst) begin
      case (state)
        IDLE:     pop = br_hs & ~i_fifo_empty;
        WAIT_CNT: begin
          // A head arriving in the timeout cycle wins over the default counter.
          pop     = ~i_fifo_empty;
          timeout = i_fifo_empty & (to_cnt == TO_LAST);
        end
        default:  ;
      endcase
    end
    load      = pop | timeout;
    taken_sel = (state == IDLE) ? i_br_taken : taken_q;
    old_cnt   = pop ? i_fifo_rdcnt : DEF_CNT;
    new_cnt   = sat_update(old_cnt, taken_sel);
    skip      = SKIP_SAT_WRITE && (new_cnt == old_cnt);
  end

  assign o_fifo_read    = pop;
  assign o_pht_wr_valid = (state == WRITE);
  assign o_pht_wr_idx   = idx_q;
  assign o_pht_wr_cnt   = cnt_q;
  assign o_upd_cnt      = upd_q;
  assign o_miss_cnt     = miss_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      taken_q <= 1'b0;
      cnt_q   <= 2'b00;
      to_cnt  <= '0;
      upd_q   <= '0;
      miss_q  <= '0;
    end else begin
      // Unchanged counters complete immediately without touching the PHT.
      if (load) begin
        cnt_q <= new_cnt;
        state <= skip ? IDLE : WRITE;
        if (skip) upd_q <= upd_q + STAT_W'(1);
      end
      if (timeout) miss_q <= miss_q + STAT_W'(1);
      case (state)
        IDLE: begin
          if (br_hs) begin
            idx_q   <= i_br_idx;
            taken_q <= i_br_taken;
            if (i_fifo_empty) begin
              to_cnt <= '0;
              state  <= WAIT_CNT;
            end
          end
        end
        WAIT_CNT: begin
          if (i_fifo_empty && !timeout) to_cnt <= to_cnt + TO_W'(1);
        end
        WRITE: begin
          if (i_pht_wr_ready) begin
            upd_q <= upd_q + STAT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_cnt_update.sv
// Self-checking bench for sat_cnt_update: directed scenarios plus randomized branches
// checked against a transaction-level reference of pop timing, write value and statistics.
module tb_sat_cnt_update;
  localparam int IDX_W  = 10;
  localparam int MT     = 4;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              br_valid, br_taken;
  logic [IDX_W-1:0]  br_idx;
  logic              br_ready;
  logic [1:0]        fifo_rdcnt;
  logic              fifo_empty;
  logic              fifo_read;
  logic              wr_valid;
  logic [IDX_W-1:0]  wr_idx;
  logic [1:0]        wr_cnt;
  logic              wr_ready;
  logic [STAT_W-1:0] upd_cnt, miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int upd_exp  = 0;
  int miss_exp = 0;

  sat_cnt_update #(.IDX_W(IDX_W), .MISS_TIMEOUT(MT), .DEF_CNT(2'b01),
                   .SKIP_SAT_WRITE(1'b1), .STAT_W(STAT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_br_valid(br_valid), .i_br_taken(br_taken),
    .i_br_idx(br_idx), .o_br_ready(br_ready), .i_fifo_rdcnt(fifo_rdcnt),
    .i_fifo_empty(fifo_empty), .o_fifo_read(fifo_read), .o_pht_wr_valid(wr_valid),
    .o_pht_wr_idx(wr_idx), .o_pht_wr_cnt(wr_cnt), .i_pht_wr_ready(wr_ready),
    .o_upd_cnt(upd_cnt), .o_miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_upd"}, 32'(upd_cnt), 32'(upd_exp % (1 << STAT_W)));
    chk({tag, "_miss"}, 32'(miss_cnt), 32'(miss_exp % (1 << STAT_W)));
  endtask

  // e: cycles the FIFO reads empty starting at the accept cycle; d: cycles of write backpressure.
  task automatic run_branch(input logic [IDX_W-1:0] idx, input logic tk, input logic [1:0] head,
                            input int e, input int d, input string tag);
    int  old_v, new_v, wc, pops;
    bit  tmo, skip;
    tmo   = (e > MT);
    old_v = tmo ? 1 : int'(head);
    new_v = tk ? ((old_v == 3) ? 3 : old_v + 1) : ((old_v == 0) ? 0 : old_v - 1);
    skip  = (new_v == old_v);
    wc    = ((e < MT) ? e : MT) + 1;
    pops  = 0;
    for (int c = 0; c < 64; c++) begin
      br_valid   = (c == 0);
      br_idx     = (c == 0) ? idx : IDX_W'($urandom);
      br_taken   = (c == 0) ? tk : 1'($urandom);
      fifo_empty = (c < e);
      fifo_rdcnt = (c == e) ? head : 2'($urandom);
      wr_ready   = (c >= wc) ? (c >= wc + d) : 1'($urandom);
      @(negedge clk);
      if (fifo_read) pops++;
      chk({tag, "_pop"}, 32'(fifo_read), 32'(c == e && !tmo));
      if (c == 0) begin
        chk({tag, "_acc_ready"}, 32'(br_ready), 32'd1);
      end else if (c < wc) begin
        chk({tag, "_wait_ready"}, 32'(br_ready), 32'd0);
        chk({tag, "_wait_wvalid"}, 32'(wr_valid), 32'd0);
      end else if (skip) begin
        chk({tag, "_skip_wvalid"}, 32'(wr_valid), 32'd0);
        chk({tag, "_skip_ready"}, 32'(br_ready), 32'd1);
        break;
      end else begin
        chk({tag, "_wvalid"}, 32'(wr_valid), 32'd1);
        chk({tag, "_widx"}, 32'(wr_idx), 32'(idx));
        chk({tag, "_wcnt"}, 32'(wr_cnt), 32'(new_v));
        chk({tag, "_wr_ready_busy"}, 32'(br_ready), 32'd0);
        if (c == wc + d) begin
          next_cycle();
          break;
        end
      end
      next_cycle();
      if (c == 63) chk({tag, "_timeout_bound"}, 32'd1, 32'd0);
    end
    if (skip) next_cycle();
    upd_exp++;
    if (tmo) miss_exp++;
    chk({tag, "_npops"}, 32'(pops), tmo ? 32'd0 : 32'd1);
    br_valid = 1'b0;
    fifo_empty = 1'b0;
    wr_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(br_ready), 32'd1);
    chk({tag, "_idle_pop"}, 32'(fifo_read), 32'd0);
    chk_stats(tag);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_taken = 1'b0; br_idx = '0;
    fifo_rdcnt = 2'b00; fifo_empty = 1'b1; wr_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(br_ready), 32'd1);
    chk("rst_wvalid", 32'(wr_valid), 32'd0);
    chk("rst_widx", 32'(wr_idx), 32'd0);
    chk("rst_wcnt", 32'(wr_cnt), 32'd0);
    chk("rst_pop", 32'(fifo_read), 32'd0);
    chk_stats("rst");
    next_cycle();

    run_branch(10'h005, 1'b1, 2'b01, 0, 0, "basic");
    run_branch(10'h0a3, 1'b1, 2'b11, 0, 0, "sat_hi");
    run_branch(10'h1c4, 1'b0, 2'b00, 0, 0, "sat_lo");
    run_branch(10'h2f0, 1'b1, 2'b11, 20, 0, "miss");
    run_branch(10'h111, 1'b0, 2'b10, 2, 0, "late_fill");
    run_branch(10'h3ff, 1'b0, 2'b01, MT, 0, "last_fill");
    run_branch(10'h07e, 1'b0, 2'b11, 0, 3, "bp");

    // Reset while a write is held off by backpressure.
    br_valid = 1'b1; br_idx = 10'h155; br_taken = 1'b1;
    fifo_empty = 1'b0; fifo_rdcnt = 2'b01; wr_ready = 1'b0;
    next_cycle();
    br_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_wvalid", 32'(wr_valid), 32'd1);
    next_cycle();
    rst = 1'b1; br_valid = 1'b1;
    @(negedge clk);
    chk("in_rst_pop", 32'(fifo_read), 32'd0);
    chk("in_rst_ready", 32'(br_ready), 32'd0);
    next_cycle();
    rst = 1'b0; br_valid = 1'b0;
    upd_exp = 0; miss_exp = 0;
    @(negedge clk);
    chk("post_rst_wvalid", 32'(wr_valid), 32'd0);
    chk("post_rst_ready", 32'(br_ready), 32'd1);
    chk("post_rst_wcnt", 32'(wr_cnt), 32'd0);
    chk_stats("post_rst");
    next_cycle();

    // Enough branches to wrap the narrow statistics counters.
    for (int i = 0; i < 50; i++) begin
      run_branch(IDX_W'($urandom), 1'($urandom), 2'($urandom),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
